io_write_port: RTL and testbench
================================

# io_write_port

Memory-mapped IO write side of the MIPS32 SoC: accepts CPU store cycles on the IO address window and drives the board-facing outputs. It owns the free-running millisecond counter, the keypad acknowledge strobe, the LED register and a multiplexed 8-digit seven-segment display scanner. It sits beside the IO read mux, which returns the `milliSeconds` value produced here.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 50_000_000: system clock frequency. Millisecond prescale is `CLK_FREQ_HZ/1000` cycles and must be ≥ 2.
- `SCAN_DIV`, 50_000: clock cycles per display digit slot. Must be ≥ 1.

Ports:
- `clk`, input, 1: system clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `addr`, input, 11: IO word address.
- `wdata`, input, 32: store data.
- `en`, input, 1: IO window select.
- `wr`, input, 1: store strobe. A write occurs when `en && wr` at a rising edge.
- `milliSeconds`, output, 32: millisecond counter.
- `keypadAck`, output, 1: one-cycle pulse that clears the keypad latch.
- `leds`, output, 16: LED register.
- `seg_an`, output, 8: digit anodes, active-low.
- `seg_cat`, output, 8: segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
Address map (writes only; data bits not listed are ignored):
- 1: keypad acknowledge; data ignored. Pulses `keypadAck`.
- 2: load `milliSeconds <= wdata` and clear the prescaler.
- 3: `leds <= wdata[15:0]`.
- 4: display value register `<= wdata`; 8 hex digits, digit 0 = `wdata[3:0]`.
- 5: digit mask `<= wdata[7:0]`; bit i enables digit i.
- Any other address, or `en=0`, or `wr=0`: no state change.

Millisecond counter:
- The prescaler counts 0..`CLK_FREQ_HZ/1000-1`.
- At the terminal count the prescaler returns to 0 and `milliSeconds` increments by 1, wrapping from 0xFFFFFFFF to 0.
- If a load (addr 2) coincides with a terminal count, the load wins: counter = `wdata`, prescaler = 0, no increment.

Display scanner:
- A slot counter counts 0..`SCAN_DIV-1`. On wrap, the digit index advances 0→7→0.
- Output registers are updated every cycle from the current index:
  - `seg_an` = one-hot-low at the index if the mask bit is set, else 8'hFF.
  - `seg_cat` = hex decode of the selected nibble, with dp off (bit 7 = 1).
- Hex patterns (active-low {dp..a}): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E.

## Timing
- Reset values: `milliSeconds`=0, prescaler=0, `keypadAck`=0, `leds`=0, display value=0, mask=8'hFF, index=0, slot counter=0, `seg_an`=8'hFF, `seg_cat`=8'hFF.
- Register writes (addr 3/4/5) are visible on outputs and internal state in the cycle after the write edge.
- Display writes reach `seg_cat`/`seg_an` one further cycle later, because the outputs are registered.
- `keypadAck` is high for exactly the one cycle after each write edge. Back-to-back writes to addr 1 hold it high for consecutive cycles.
- `milliSeconds` increments exactly once per `CLK_FREQ_HZ/1000` cycles. With no intervening load, the first increment appears `CLK_FREQ_HZ/1000` cycles after reset deassertion.
- First cycle after reset release: `seg_an`=8'hFE, `seg_cat`=8'hC0.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronously). A write on the same edge as a reset release is honoured normally.

## Configuration
- `IO_WRITE_DISPLAY_EN` defined: the display value/mask registers, scanner and decoder are compiled in.
- `IO_WRITE_DISPLAY_EN` undefined:
  - The scanner logic is absent.
  - `seg_an` and `seg_cat` are tied to 8'hFF.
  - Writes to addr 4/5 are ignored.
  - All other behaviour is unchanged.

## Structure
- Shared package `io_pkg` holds:
  - the IO address constants (`IO_ADDR_KEYPAD`=1, `IO_ADDR_MS`=2, `IO_ADDR_LEDS`=3, `IO_ADDR_DISP`=4, `IO_ADDR_DMASK`=5), also used by the read mux;
  - the 16 seven-segment pattern constants.
- One sub-module: `seven_seg_decoder` (4-bit nibble in, 8-bit active-low pattern out; combinational).

## Test plan
Bench parameters: `CLK_FREQ_HZ`=4000 (4 cycles/ms), `SCAN_DIV`=2.

- Reset, then run 40 cycles with no writes → `milliSeconds`=10; `leds`=0; `keypadAck` never high.
- Write addr 2 data 0xFFFFFFFE, then run 8 cycles → counter reads 0xFFFFFFFF and then 0x00000000 (wrap). Also issue a load of 0x100 on a terminal-count edge → next cycle reads 0x100, with no 0x101 until 4 cycles later.
- Write addr 4 data 0x0000F0A9 with mask 0xFF → over 16 cycles:
  - `seg_cat` shows 90, 88, C0, 8E, then C0 ×4;
  - `seg_an` walks FE, FD, FB, F7, EF, DF, BF, 7F, with 2 cycles each.
- Write addr 5 data 0x01 → `seg_an`=8'hFF in all slots except index 0 (FE).
- Write addr 1 on two consecutive cycles, then addr 3 data 0xFFFFABCD → `keypadAck` high exactly 2 cycles; `leds`=0xABCD. Writes with `en`=0 or to addr 7 change nothing.
- Assert `rst` mid-scan with non-zero registers → all outputs at reset values during reset. Build without `IO_WRITE_DISPLAY_EN` → `seg_an`/`seg_cat` remain 8'hFF after an addr 4 write.

Source files
------------

// File: rtl/io_pkg.sv
// Shared IO constants for the MIPS32 SoC: store/load address map and
// active-low seven-segment patterns ({dp,g,f,e,d,c,b,a}).
package io_pkg;

    localparam logic [10:0] IO_ADDR_KEYPAD = 11'd1;
    localparam logic [10:0] IO_ADDR_MS     = 11'd2;
    localparam logic [10:0] IO_ADDR_LEDS   = 11'd3;
    localparam logic [10:0] IO_ADDR_DISP   = 11'd4;
    localparam logic [10:0] IO_ADDR_DMASK  = 11'd5;

    localparam logic [7:0] SEG_HEX_0 = 8'hC0;
    localparam logic [7:0] SEG_HEX_1 = 8'hF9;
    localparam logic [7:0] SEG_HEX_2 = 8'hA4;
    localparam logic [7:0] SEG_HEX_3 = 8'hB0;
    localparam logic [7:0] SEG_HEX_4 = 8'h99;
    localparam logic [7:0] SEG_HEX_5 = 8'h92;
    localparam logic [7:0] SEG_HEX_6 = 8'h82;
    localparam logic [7:0] SEG_HEX_7 = 8'hF8;
    localparam logic [7:0] SEG_HEX_8 = 8'h80;
    localparam logic [7:0] SEG_HEX_9 = 8'h90;
    localparam logic [7:0] SEG_HEX_A = 8'h88;
    localparam logic [7:0] SEG_HEX_B = 8'h83;
    localparam logic [7:0] SEG_HEX_C = 8'hC6;
    localparam logic [7:0] SEG_HEX_D = 8'hA1;
    localparam logic [7:0] SEG_HEX_E = 8'h86;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module seven_seg_decoder
    import io_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_pattern
);

    always_comb begin
        o_pattern = 8'hFF;
        case (i_nibble)
            4'h0: o_pattern = SEG_HEX_0;
            4'h1: o_pattern = SEG_HEX_1;
            4'h2: o_pattern = SEG_HEX_2;
            4'h3: o_pattern = SEG_HEX_3;
            4'h4: o_pattern = SEG_HEX_4;
            4'h5: o_pattern = SEG_HEX_5;
            4'h6: o_pattern = SEG_HEX_6;
            4'h7: o_pattern = SEG_HEX_7;
            4'h8: o_pattern = SEG_HEX_8;
            4'h9: o_pattern = SEG_HEX_9;
            4'hA: o_pattern = SEG_HEX_A;
            4'hB: o_pattern = SEG_HEX_B;
            4'hC: o_pattern = SEG_HEX_C;
            4'hD: o_pattern = SEG_HEX_D;
            4'hE: o_pattern = SEG_HEX_E;
            default: o_pattern = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/io_write_port.sv
// IO write side: millisecond counter, keypad ack, LEDs and 8-digit display scanner.
// Define IO_WRITE_DISPLAY_EN to build the display registers and scanner.
module io_write_port
    import io_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SCAN_DIV    = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] addr,
    input  logic [31:0] wdata,
    input  logic        en,
    input  logic        wr,
    output logic [31:0] milliSeconds,
    output logic        keypadAck,
    output logic [15:0] leds,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam int MS_DIV = CLK_FREQ_HZ / 1000;
    localparam int PW     = $clog2(MS_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(MS_DIV - 1);

    logic          w_write;
    logic [PW-1:0] r_prescale;

    assign w_write = en && wr;

    // A load always beats the terminal-count increment on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            milliSeconds <= 32'd0;
            r_prescale   <= '0;
            keypadAck    <= 1'b0;
            leds         <= 16'd0;
        end else begin
            keypadAck <= w_write && (addr == IO_ADDR_KEYPAD);
            if (w_write && (addr == IO_ADDR_LEDS)) begin
                leds <= wdata[15:0];
            end
            if (w_write && (addr == IO_ADDR_MS)) begin
                milliSeconds <= wdata;
                r_prescale   <= '0;
            end else if (r_prescale == PRE_LAST) begin
                milliSeconds <= milliSeconds + 32'd1;
                r_prescale   <= '0;
            end else begin
                r_prescale <= r_prescale + 1'b1;
            end
        end
    end

`ifdef IO_WRITE_DISPLAY_EN
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [31:0]   r_dispVal;
    logic [7:0]    r_dmask;
    logic [SW-1:0] r_slot;
    logic [2:0]    r_index;
    logic [3:0]    w_nibble;
    logic [7:0]    w_pattern;

    assign w_nibble = r_dispVal[{r_index, 2'b00} +: 4];

    seven_seg_decoder u_decoder (
        .i_nibble  (w_nibble),
        .o_pattern (w_pattern)
    );

    // Outputs are registered from the pre-edge index, so they trail the scanner by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dispVal <= 32'd0;
            r_dmask   <= 8'hFF;
            r_slot    <= '0;
            r_index   <= 3'd0;
            seg_an    <= 8'hFF;
            seg_cat   <= 8'hFF;
        end else begin
            if (w_write && (addr == IO_ADDR_DISP)) begin
                r_dispVal <= wdata;
            end
            if (w_write && (addr == IO_ADDR_DMASK)) begin
                r_dmask <= wdata[7:0];
            end
            if (r_slot == SLOT_LAST) begin
                r_slot  <= '0;
                r_index <= r_index + 3'd1;
            end else begin
                r_slot <= r_slot + 1'b1;
            end
            seg_an  <= r_dmask[r_index] ? ~(8'h01 << r_index) : 8'hFF;
            seg_cat <= {1'b1, w_pattern[6:0]};
        end
    end
`else
    logic w_unused;

    assign w_unused = &{1'b0, wdata[31:16], SCAN_DIV[0]};
    assign seg_an   = 8'hFF;
    assign seg_cat  = 8'hFF;
`endif

endmodule

// File: tb/tb_io_write_port.sv
// Scoreboard bench for io_write_port: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_io_write_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] addr = 11'd0;
    logic [31:0] wdata = 32'd0;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] milliSeconds;
    logic        keypadAck;
    logic [15:0] leds;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    always #5 clk = ~clk;

    io_write_port #(
        .CLK_FREQ_HZ (4000),
        .SCAN_DIV    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .en           (en),
        .wr           (wr),
        .milliSeconds (milliSeconds),
        .keypadAck    (keypadAck),
        .leds         (leds),
        .seg_an       (seg_an),
        .seg_cat      (seg_cat)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    int          rstCyc = 0;
    int          msL = 0;
    logic [31:0] msV = 32'd0;

    logic [7:0] anWalk [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] anMask [8] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] catA   [8] = '{8'h90, 8'h88, 8'hC0, 8'h8E, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    logic [7:0] catB   [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    logic [7:0] catC   [8] = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always @(posedge clk) cycle = cycle + 1;

    function automatic logic [31:0] msAt(int c);
        return msV + 32'((c - msL) / 4);
    endfunction

    function automatic logic [31:0] actualOf(int sel);
        case (sel)
            0: return milliSeconds;
            1: return {31'd0, keypadAck};
            2: return {16'd0, leds};
            3: return {24'd0, seg_an};
            default: return {24'd0, seg_cat};
        endcase
    endfunction

    function automatic string nameOf(int sel);
        case (sel)
            0: return "milliSeconds";
            1: return "keypadAck";
            2: return "leds";
            3: return "seg_an";
            default: return "seg_cat";
        endcase
    endfunction

    // Monitor: every expectation due this cycle is compared; overdue ones count as failures.
    always @(negedge clk) begin : monitor
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc <= cycle) begin
                act = actualOf(q[i].sel);
                checks = checks + 1;
                if (q[i].cyc < cycle || act !== q[i].val) begin
                    errors = errors + 1;
                    $display("[TB] FAIL %s cycle %0d: got %h expected %h",
                             nameOf(q[i].sel), q[i].cyc, act, q[i].val);
                end
                q.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    task automatic expectAt(int c, int sel, logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(logic [10:0] a, logic [31:0] d, logic e, logic w);
        en    = e;
        wr    = w;
        addr  = a;
        wdata = d;
        tick();
        en = 1'b0;
        wr = 1'b0;
    endtask

    task automatic pushBasic(int c, logic [15:0] ledsExp, logic ackExp);
        expectAt(c, 0, msAt(c));
        expectAt(c, 1, {31'd0, ackExp});
        expectAt(c, 2, {16'd0, ledsExp});
    endtask

    task automatic pushDisplay(int c, logic [7:0] an, logic [7:0] cat);
`ifdef IO_WRITE_DISPLAY_EN
        expectAt(c, 3, {24'd0, an});
        expectAt(c, 4, {24'd0, cat});
`else
        expectAt(c, 3, 32'h0000_00FF);
        expectAt(c, 4, 32'h0000_00FF);
`endif
    endtask

    task automatic pushReset(int c);
        expectAt(c, 0, 32'd0);
        expectAt(c, 1, 32'd0);
        expectAt(c, 2, 32'd0);
        expectAt(c, 3, 32'h0000_00FF);
        expectAt(c, 4, 32'h0000_00FF);
    endtask

    task automatic checkOutput(int s, logic [7:0] cat [8], logic [7:0] an [8], logic [15:0] ledsExp);
        for (int k = 0; k < 16; k++) begin
            pushBasic(s + k, ledsExp, 1'b0);
            pushDisplay(s + k, an[k / 2], cat[k / 2]);
        end
    endtask

    task automatic alignDisplay();
        while (((cycle + 1 - rstCyc) % 16) != 0) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int e;
        int t;
        int s;

        repeat (3) tick();
        pushReset(cycle);
        tick();
        rst    = 1'b0;
        rstCyc = cycle;
        msL    = cycle;
        msV    = 32'd0;

        $display("[TB] idle count for 40 cycles");
        for (int c = rstCyc + 1; c <= rstCyc + 40; c++) pushBasic(c, 16'd0, 1'b0);
        pushDisplay(rstCyc + 1, 8'hFE, 8'hC0);
        repeat (40) tick();
        checks = checks + 1;
        if (milliSeconds !== 32'd10) begin
            errors = errors + 1;
            $display("[TB] FAIL idle milliSeconds: got %h expected %h", milliSeconds, 32'd10);
        end
        checks = checks + 1;
        if (leds !== 16'd0) begin
            errors = errors + 1;
            $display("[TB] FAIL idle leds: got %h expected 0000", leds);
        end
        checks = checks + 1;
        if (keypadAck !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL idle keypadAck: got %b expected 0", keypadAck);
        end

        $display("[TB] millisecond load and wrap");
        e   = cycle + 1;
        msL = e;
        msV = 32'hFFFF_FFFE;
        for (int c = e; c <= e + 8; c++) pushBasic(c, 16'd0, 1'b0);
        applyStimulus(11'd2, 32'hFFFF_FFFE, 1'b1, 1'b1);
        repeat (8) tick();

        $display("[TB] load on terminal count");
        while (((cycle + 1 - msL) % 4) != 0) tick();
        pushBasic(cycle, 16'd0, 1'b0);
        t   = cycle + 1;
        msL = t;
        msV = 32'h0000_0100;
        for (int c = t; c <= t + 4; c++) pushBasic(c, 16'd0, 1'b0);
        applyStimulus(11'd2, 32'h0000_0100, 1'b1, 1'b1);
        repeat (4) tick();

        $display("[TB] keypad ack, leds and ignored writes");
        e = cycle + 1;
        pushBasic(e - 1, 16'd0, 1'b0);
        pushBasic(e, 16'd0, 1'b1);
        pushBasic(e + 1, 16'd0, 1'b1);
        for (int c = e + 2; c <= e + 8; c++) pushBasic(c, 16'hABCD, 1'b0);
        applyStimulus(11'd1, 32'd0, 1'b1, 1'b1);
        applyStimulus(11'd1, 32'd0, 1'b1, 1'b1);
        applyStimulus(11'd3, 32'hFFFF_ABCD, 1'b1, 1'b1);
        applyStimulus(11'd3, 32'h0000_1234, 1'b0, 1'b1);
        applyStimulus(11'd7, 32'h0000_FFFF, 1'b1, 1'b1);
        applyStimulus(11'd1, 32'd0, 1'b1, 1'b0);
        applyStimulus(11'd1, 32'd0, 1'b0, 1'b1);
        repeat (2) tick();
        checks = checks + 1;
        if (leds !== 16'hABCD) begin
            errors = errors + 1;
            $display("[TB] FAIL leds after ignored writes: got %h expected ABCD", leds);
        end
        checks = checks + 1;
        if (keypadAck !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL keypadAck after ignored writes: got %b expected 0", keypadAck);
        end

        $display("[TB] display scan patterns");
        alignDisplay();
        s = cycle + 2;
        checkOutput(s, catA, anWalk, 16'hABCD);
        applyStimulus(11'd4, 32'h0000_F0A9, 1'b1, 1'b1);
        repeat (16) tick();

        alignDisplay();
        s = cycle + 2;
        checkOutput(s, catB, anWalk, 16'hABCD);
        applyStimulus(11'd4, 32'h7654_3210, 1'b1, 1'b1);
        repeat (16) tick();

        alignDisplay();
        s = cycle + 2;
        checkOutput(s, catC, anWalk, 16'hABCD);
        applyStimulus(11'd4, 32'hFEDC_BA98, 1'b1, 1'b1);
        repeat (16) tick();

        $display("[TB] digit mask");
        alignDisplay();
        s = cycle + 2;
        checkOutput(s, catC, anMask, 16'hABCD);
        applyStimulus(11'd5, 32'h0000_0001, 1'b1, 1'b1);
        repeat (16) tick();
        checks = checks + 1;
        if (leds !== 16'hABCD) begin
            errors = errors + 1;
            $display("[TB] FAIL leds after display writes: got %h expected ABCD", leds);
        end

        $display("[TB] reset mid-scan and write on release edge");
        applyStimulus(11'd5, 32'h0000_00FF, 1'b1, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        e   = cycle;
        for (int c = e; c <= e + 3; c++) pushReset(c);
        repeat (3) tick();
        checks = checks + 1;
        if (milliSeconds !== 32'd0) begin
            errors = errors + 1;
            $display("[TB] FAIL reset milliSeconds: got %h expected 0", milliSeconds);
        end
        checks = checks + 1;
        if (leds !== 16'd0) begin
            errors = errors + 1;
            $display("[TB] FAIL reset leds: got %h expected 0", leds);
        end
        checks = checks + 1;
        if (seg_an !== 8'hFF) begin
            errors = errors + 1;
            $display("[TB] FAIL reset seg_an: got %h expected FF", seg_an);
        end
        checks = checks + 1;
        if (seg_cat !== 8'hFF) begin
            errors = errors + 1;
            $display("[TB] FAIL reset seg_cat: got %h expected FF", seg_cat);
        end
        @(negedge clk);
        #1;
        rstCyc = e + 3;
        msL    = e + 3;
        msV    = 32'd0;
        for (int c = e + 4; c <= e + 12; c++) pushBasic(c, 16'h5A5A, 1'b0);
        pushDisplay(e + 4, 8'hFE, 8'hC0);
        pushDisplay(e + 5, 8'hFE, 8'hC0);
        pushDisplay(e + 6, 8'hFD, 8'hC0);
        rst   = 1'b0;
        en    = 1'b1;
        wr    = 1'b1;
        addr  = 11'd3;
        wdata = 32'h0000_5A5A;
        tick();
        en = 1'b0;
        wr = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        #1;

        while (q.size() > 0) begin
            errors = errors + 1;
            $display("[TB] FAIL unchecked %s cycle %0d: got none expected %h",
                     nameOf(q[0].sel), q[0].cyc, q[0].val);
            q.delete(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
